ps2_host_tx: RTL
================

Name: ps2_host_tx

Overview:
Host-to-device PS/2 transmitter, the send side of the PS/2 keyboard port. It sends command bytes to the keyboard, such as 0xED (set LEDs) and 0xFF (reset). A CPU write on the simple bus loads a byte. The block then runs the PS/2 host request-to-send sequence on open-drain clock and data lines. It exposes busy, done and error status back to the CPU.

Parameters:
INHIBIT_CYCLES, 5000, io_read_clk cycles the PS/2 clock is held low before the start bit (100 us at 50 MHz).
TIMEOUT_CYCLES, 750000, maximum cycles from clock release to return to idle (15 ms at 50 MHz).
FILTER_LEN, 4, consecutive equal synchronized samples needed to accept a new PS/2 clock level.

Ports:
io_read_clk  in  1  system/bus clock
rst  in  1  asynchronous, active-high reset
dat_i  in  8  bus write data (command byte)
we_i  in  1  bus write enable
stb_i  in  1  bus strobe
dat_o  out  8  status: {5'b0, tx_err, tx_done, busy}
ack_o  out  1  bus acknowledge
ps2_clk_i  in  1  PS/2 clock line level (async)
ps2_data_i  in  1  PS/2 data line level (async)
ps2_clk_oe  out  1  1 = drive PS/2 clock low, 0 = release
ps2_data_oe  out  1  1 = drive PS/2 data low, 0 = release
busy  out  1  transfer in progress; the receiver may ignore line activity while this is high

Behaviour:
- Reset is asynchronous on rst. The clock is io_read_clk.
- Reset values: ps2_clk_oe=0, ps2_data_oe=0, busy=0, tx_done=0, tx_err=0, dat_o=0, state=IDLE. Both lines are released immediately, including mid-frame.
- ack_o = stb_i (combinational, zero wait states).
- dat_o is registered; it is updated every cycle with the status vector.
- Accepted write: stb_i&we_i in IDLE. It latches dat_i, computes parity = ~^dat_i (odd parity), clears tx_done/tx_err, and enters INHIBIT on the next edge.
- A write while busy is ignored: no state change, no flag change.
- Read: stb_i&~we_i. It clears tx_done and tx_err on that edge. If a completion or error event lands on the same edge, the event wins and its flag is set.
- Clock line input: 2-FF synchronizer, then the FILTER_LEN filter. fall = filtered level goes 1->0, one-cycle pulse.
- States:
  - IDLE: both oe=0, busy=0.
  - INHIBIT: clk_oe=1, data_oe=0, busy=1. Counts INHIBIT_CYCLES, then goes to START.
  - START: clk_oe=1, data_oe=1 (start bit) for 1 cycle, then goes to CLKREL.
  - CLKREL: clk_oe=0, data_oe=1. Clears the bit counter and the timeout counter; goes to SHIFT.
  - SHIFT: on each fall, present the next bit with data_oe = ~bit.
    - Order: d0..d7 (LSB first), parity, stop (stop => data_oe=0).
    - The 10th fall presents the stop bit; go to ACK.
  - ACK: data_oe=0. On the next fall, sample the synchronized data.
    - Data low: ack ok, go to WAITIDLE.
    - Data high: go to ERR.
  - WAITIDLE: wait until the filtered clock and synchronized data are both 1. Then pulse tx_done (set sticky) and go to IDLE.
  - ERR: set tx_err, release both lines, go to IDLE (1 cycle).
- Timeout counter runs in CLKREL..WAITIDLE. Reaching TIMEOUT_CYCLES in any of these states goes to ERR.
- busy = (state != IDLE).
- Counters are sized by $clog2 of their parameter. They saturate and never wrap.
- A clock glitch shorter than FILTER_LEN cycles must not produce fall.

Decomposition:
- Shared package ps2_pkg: state enum (IDLE, INHIBIT, START, CLKREL, SHIFT, ACK, WAITIDLE, ERR), status bit indices (STAT_BUSY=0, STAT_DONE=1, STAT_ERR=2), and the frame length constant PS2_TX_BITS=10.
- One sub-module, ps2_line_filter: 2-FF synchronizer, FILTER_LEN filter and fall pulse. It is instantiated for the clock line. The data line uses only the synchronizer portion.

Test Plan:
- Setup for all scenarios: INHIBIT_CYCLES=8, TIMEOUT_CYCLES=2000, FILTER_LEN=2; the device model clocks at a 40-cycle period.
- Write 0xED, device acks -> clk_oe=1 for 8 cycles, then data_oe=1 for the start bit. Device sees bits 1,0,1,1,0,1,1,1, parity 1, stop 1. Then tx_done=1, busy=0, status read = 0x02 and the next read = 0x00.
- Write 0x00 -> parity bit presented = 1. Write 0xFF -> parity bit = 1. Write 0x01 -> parity bit = 0.
- Device never drives ack low -> after the 11th fall, tx_err=1, status=0x04, both oe=0.
- Device stops clocking after 4 bits -> ERR when the timeout counter reaches 2000, tx_err=1, lines released.
- Write 0x55 while busy, then rst asserted mid-SHIFT -> the 0x55 is ignored (the original byte frame continues). On rst, both oe=0 asynchronously and status=0x00.
- 1-cycle low glitch on ps2_clk_i during SHIFT -> no bit advance. The frame completes correctly with tx_done=1.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host transmitter.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        START,
        CLKREL,
        SHIFT,
        ACK,
        WAITIDLE,
        ERR
    } ps2_state_t;

    localparam int STAT_BUSY   = 0;
    localparam int STAT_DONE   = 1;
    localparam int STAT_ERR    = 2;
    localparam int PS2_TX_BITS = 10;

    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_host_tx_line_filter.sv
// 2-FF synchronizer plus FILTER_LEN-sample debounce and a one-cycle fall pulse.
module ps2_line_filter #(
    parameter int FILTER_LEN = 4
) (
    input  logic io_read_clk,
    input  logic rst,
    input  logic line_i,
    output logic level_o,
    output logic fall_o
);

    localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER_LEN - 1);

    logic             meta_q;
    logic             sync_q;
    logic             level_q;
    logic             fall_q;
    logic [CNT_W-1:0] cnt_q;

    // Idle PS/2 lines are pulled high, so every stage resets to 1.
    always_ff @(posedge io_read_clk or posedge rst) begin
        if (rst) begin
            meta_q  <= 1'b1;
            sync_q  <= 1'b1;
            level_q <= 1'b1;
            fall_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            meta_q <= line_i;
            sync_q <= meta_q;
            fall_q <= 1'b0;
            if (sync_q == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q >= CNT_MAX) begin
                level_q <= sync_q;
                cnt_q   <= '0;
                fall_q  <= level_q;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign level_o = level_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: bus write loads a command byte, the FSM runs
// the request-to-send sequence on open-drain clock/data and reports status.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000,
    parameter int FILTER_LEN     = 4
) (
    input  logic       io_read_clk,
    input  logic       rst,
    input  logic [7:0] dat_i,
    input  logic       we_i,
    input  logic       stb_i,
    output logic [7:0] dat_o,
    output logic       ack_o,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy
);

    localparam int INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
    localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int BIT_W = $clog2(PS2_TX_BITS + 1);
    localparam logic [INH_W-1:0] INH_MAX  = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(PS2_TX_BITS - 1);

    ps2_state_t       state_q, state_d;
    logic [INH_W-1:0] inh_cnt_q, inh_cnt_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [PS2_TX_BITS-1:0] frame_q, frame_d;
    logic             bit_q, bit_d;
    logic             tx_done_q, tx_done_d;
    logic             tx_err_q, tx_err_d;
    logic [7:0]       dat_o_q;
    logic             data_meta_q, data_sync_q;
    logic             clk_level, clk_fall;
    logic             clk_oe_c, data_oe_c;
    logic             timeout;

    ps2_line_filter #(
        .FILTER_LEN(FILTER_LEN)
    ) u_clk_filter (
        .io_read_clk(io_read_clk),
        .rst        (rst),
        .line_i     (ps2_clk_i),
        .level_o    (clk_level),
        .fall_o     (clk_fall)
    );

    // The ack bit only needs a clean level, not debouncing.
    always_ff @(posedge io_read_clk or posedge rst) begin
        if (rst) begin
            data_meta_q <= 1'b1;
            data_sync_q <= 1'b1;
        end else begin
            data_meta_q <= ps2_data_i;
            data_sync_q <= data_meta_q;
        end
    end

    always_ff @(posedge io_read_clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            inh_cnt_q <= '0;
            to_cnt_q  <= '0;
            bit_cnt_q <= '0;
            frame_q   <= '0;
            bit_q     <= 1'b0;
            tx_done_q <= 1'b0;
            tx_err_q  <= 1'b0;
            dat_o_q   <= '0;
        end else begin
            state_q   <= state_d;
            inh_cnt_q <= inh_cnt_d;
            to_cnt_q  <= to_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            frame_q   <= frame_d;
            bit_q     <= bit_d;
            tx_done_q <= tx_done_d;
            tx_err_q  <= tx_err_d;
            dat_o_q   <= {5'b0, tx_err_d, tx_done_d, state_d != IDLE};
        end
    end

    always_comb begin
        state_d   = state_q;
        inh_cnt_d = inh_cnt_q;
        to_cnt_d  = to_cnt_q;
        bit_cnt_d = bit_cnt_q;
        frame_d   = frame_q;
        bit_d     = bit_q;
        tx_done_d = tx_done_q;
        tx_err_d  = tx_err_q;
        clk_oe_c  = 1'b0;
        data_oe_c = 1'b0;
        timeout   = (to_cnt_q == TO_MAX);

        // A read clears the sticky flags; an event on the same edge overrides below.
        if (stb_i && !we_i) begin
            tx_done_d = 1'b0;
            tx_err_d  = 1'b0;
        end

        if ((state_q == SHIFT || state_q == ACK || state_q == WAITIDLE) && !timeout) begin
            to_cnt_d = to_cnt_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (stb_i && we_i) begin
                    frame_d   = {1'b1, odd_parity(dat_i), dat_i};
                    tx_done_d = 1'b0;
                    tx_err_d  = 1'b0;
                    inh_cnt_d = '0;
                    state_d   = INHIBIT;
                end
            end
            INHIBIT: begin
                clk_oe_c = 1'b1;
                if (inh_cnt_q == INH_MAX) begin
                    state_d = START;
                end else begin
                    inh_cnt_d = inh_cnt_q + 1'b1;
                end
            end
            START: begin
                clk_oe_c  = 1'b1;
                data_oe_c = 1'b1;
                state_d   = CLKREL;
            end
            CLKREL: begin
                data_oe_c = 1'b1;
                bit_cnt_d = '0;
                to_cnt_d  = '0;
                bit_d     = 1'b0;
                state_d   = SHIFT;
            end
            SHIFT: begin
                data_oe_c = ~bit_q;
                if (timeout) begin
                    state_d = ERR;
                end else if (clk_fall) begin
                    bit_d     = frame_q[bit_cnt_q];
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == BIT_LAST) begin
                        state_d = ACK;
                    end
                end
            end
            ACK: begin
                if (timeout) begin
                    state_d = ERR;
                end else if (clk_fall) begin
                    state_d = data_sync_q ? ERR : WAITIDLE;
                end
            end
            WAITIDLE: begin
                if (timeout) begin
                    state_d = ERR;
                end else if (clk_level && data_sync_q) begin
                    tx_done_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            ERR: begin
                tx_err_d = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign ps2_clk_oe  = clk_oe_c;
    assign ps2_data_oe = data_oe_c;
    assign busy        = (state_q != IDLE);
    assign dat_o       = dat_o_q;
    assign ack_o       = stb_i;

endmodule
